// File: rtl/skinny_round_ctrl.sv
// Round-sequencing controller for an unrolled SKINNY-128-384 datapath (numrnd rounds/cycle).
// Optional abort port enabled by defining SKINNY_CTRL_ABORT_EN.
module skinny_round_ctrl #(
  parameter int numrnd = 4,
  parameter int totrnd = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  in_ready_o,
  input  logic [127:0]          state_i,
  input  logic [127:0]          key_i,
  input  logic [127:0]          tweak_i,
  input  logic [127:0]          cnt_i,
`ifdef SKINNY_CTRL_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic [127:0]          dp_state_o,
  output logic [127:0]          dp_key_o,
  output logic [127:0]          dp_tweak_o,
  output logic [127:0]          dp_cnt_o,
  output logic [6*numrnd-1:0]   dp_constant_o,
  input  logic [127:0]          dp_nextstate_i,
  input  logic [127:0]          dp_nextkey_i,
  input  logic [127:0]          dp_nexttweak_i,
  input  logic [127:0]          dp_nextcnt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [127:0]          state_o
);

  localparam int NSTEP = totrnd / numrnd;
  localparam int CW    = $clog2(NSTEP) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_e;

  st_e               st_q, st_d;
  logic [127:0]      state_q, state_d, key_q, key_d, tweak_q, tweak_d, cnt_q, cnt_d;
  logic [5:0]        rc_q, rc_d;
  logic [CW-1:0]     rnd_q, rnd_d;
  logic [numrnd:0][5:0] rc_chain;
  logic              accept;

  // Constant for round i of this cycle is the LFSR register advanced i+1 steps.
  assign rc_chain[0] = rc_q;
  for (genvar i = 0; i < numrnd; i++) begin : g_rc
    assign rc_chain[i+1] = {rc_chain[i][4:0], rc_chain[i][5] ^ rc_chain[i][4] ^ 1'b1};
    assign dp_constant_o[6*i +: 6] = rc_chain[i+1];
  end

`ifdef SKINNY_CTRL_ABORT_EN
  assign in_ready_o = (st_q == IDLE) | ((st_q == DONE) & out_ready_i & ~abort_i);
`else
  assign in_ready_o = (st_q == IDLE) | ((st_q == DONE) & out_ready_i);
`endif
  assign accept = start_i & in_ready_o;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    tweak_d = tweak_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    rnd_d   = rnd_q;
    unique case (st_q)
      RUN: begin
        state_d = dp_nextstate_i;
        key_d   = dp_nextkey_i;
        tweak_d = dp_nexttweak_i;
        cnt_d   = dp_nextcnt_i;
        rc_d    = rc_chain[numrnd];
        rnd_d   = rnd_q + CW'(1);
        if (rnd_q == CW'(NSTEP - 1)) st_d = DONE;
      end
      DONE: if (out_ready_i) st_d = IDLE;
      default: ;
    endcase
    // Accept in DONE overrides the return to IDLE: back-to-back blocks, no bubble.
    if (accept) begin
      st_d    = RUN;
      state_d = state_i;
      key_d   = key_i;
      tweak_d = tweak_i;
      cnt_d   = cnt_i;
      rc_d    = 6'h00;
      rnd_d   = '0;
    end
`ifdef SKINNY_CTRL_ABORT_EN
    if (abort_i && st_q != IDLE) begin
      st_d    = IDLE;
      state_d = '0;
      key_d   = '0;
      tweak_d = '0;
      cnt_d   = '0;
      rc_d    = 6'h00;
      rnd_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      tweak_q <= '0;
      cnt_q   <= '0;
      rc_q    <= 6'h00;
      rnd_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      tweak_q <= tweak_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      rnd_q   <= rnd_d;
    end
  end

  assign dp_state_o  = state_q;
  assign dp_key_o    = key_q;
  assign dp_tweak_o  = tweak_q;
  assign dp_cnt_o    = cnt_q;
  assign state_o     = state_q;
  assign out_valid_o = (st_q == DONE);

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Bench for skinny_round_ctrl: surrogate round function as datapath, block-level reference model.
module tb_skinny_round_ctrl;
  localparam int NR = 4;
  localparam int TR = 40;
  localparam int NS = TR / NR;

  typedef struct packed {
    logic [127:0] s, k, t, c;
  } blk_t;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, out_ready_i = 1'b0;
  logic [127:0] state_i = '0, key_i = '0, tweak_i = '0, cnt_i = '0;
`ifdef SKINNY_CTRL_ABORT_EN
  logic abort_i = 1'b0;
`endif
  logic         in_ready_o, out_valid_o;
  logic [127:0] dp_state_o, dp_key_o, dp_tweak_o, dp_cnt_o, state_o;
  logic [127:0] dp_nextstate_i, dp_nextkey_i, dp_nexttweak_i, dp_nextcnt_i;
  logic [6*NR-1:0] dp_constant_o;

  int n_chk = 0, n_fail = 0;
  logic [5:0] rc_tab [TR];

  always #5 clk = ~clk;

  skinny_round_ctrl #(.numrnd(NR), .totrnd(TR)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_ready_o(in_ready_o),
    .state_i(state_i), .key_i(key_i), .tweak_i(tweak_i), .cnt_i(cnt_i),
`ifdef SKINNY_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .dp_state_o(dp_state_o), .dp_key_o(dp_key_o), .dp_tweak_o(dp_tweak_o), .dp_cnt_o(dp_cnt_o),
    .dp_constant_o(dp_constant_o),
    .dp_nextstate_i(dp_nextstate_i), .dp_nextkey_i(dp_nextkey_i),
    .dp_nexttweak_i(dp_nexttweak_i), .dp_nextcnt_i(dp_nextcnt_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .state_o(state_o)
  );

  // One surrogate round: mixes every register and the round constant.
  function automatic blk_t rnd(blk_t b, logic [5:0] rc);
    blk_t r;
    r.s = {b.s[120:0], b.s[127:121]} ^ b.k ^ b.t ^ b.c ^ {122'd0, rc};
    r.k = {b.k[119:0], b.k[127:120]} ^ 128'h5;
    r.t = b.t + 128'd1;
    r.c = {b.c[124:0], b.c[127:125]} ^ {122'd0, rc};
    return r;
  endfunction

  blk_t dp_out;
  always_comb begin
    dp_out = {dp_state_o, dp_key_o, dp_tweak_o, dp_cnt_o};
    for (int i = 0; i < NR; i++) dp_out = rnd(dp_out, dp_constant_o[6*i +: 6]);
  end
  assign dp_nextstate_i = dp_out.s;
  assign dp_nextkey_i   = dp_out.k;
  assign dp_nexttweak_i = dp_out.t;
  assign dp_nextcnt_i   = dp_out.c;

  function automatic blk_t model(blk_t b, int n);
    blk_t r = b;
    for (int i = 0; i < n; i++) r = rnd(r, rc_tab[i]);
    return r;
  endfunction

  function automatic logic [6*NR-1:0] exp_const(int cyc);
    logic [6*NR-1:0] r = '0;
    for (int i = 0; i < NR; i++) r[6*i +: 6] = rc_tab[NR*cyc + i];
    return r;
  endfunction

  function automatic blk_t rand_blk();
    blk_t r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input blk_t b);
    state_i = b.s; key_i = b.k; tweak_i = b.t; cnt_i = b.c;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (out_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("valid_timeout", out_valid_o, 1'b1);
  endtask

  // Full block with 'hold' cycles of back-pressure before the result is taken.
  task automatic run_txn(input string tag, input int hold);
    blk_t b;
    int n;
    b = rand_blk();
    drive(b);
    start_i = 1'b1; out_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    wait_valid(NS + 5, n);
    check({tag, "_latency"}, n, NS);
    check({tag, "_ct"}, state_o, model(b, TR).s);
    repeat (hold) tick();
    check({tag, "_held_valid"}, out_valid_o, 1'b1);
    check({tag, "_held_ct"}, state_o, model(b, TR).s);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_released"}, out_valid_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    blk_t b, b2;
    int n, v;
    logic seen;

    v = 0;
    for (int r = 0; r < TR; r++) begin
      v = (2 * v) % 64 + ((v / 32 + v / 16 + 1) % 2);
      rc_tab[r] = 6'(v);
    end

    // Reset state
    @(negedge clk);
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_dp_state", dp_state_o, 128'd0);
    check("rst_dp_key", dp_key_o, 128'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", in_ready_o, 1'b1);
    check("idle_state_o", state_o, 128'd0);
    check("idle_const", dp_constant_o, 24'h3C70C1);

    // Block 1: per-cycle register/constant tracking, start_i noise during RUN
    b = rand_blk();
    drive(b);
    start_i = 1'b1; out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("acc_ready", in_ready_o, 1'b0);
    check("acc_key", dp_key_o, b.k);
    check("acc_tweak", dp_tweak_o, b.t);
    check("acc_cnt", dp_cnt_o, b.c);
    check("first_const", dp_constant_o, 24'h3C70C1);
    for (int k = 0; k < NS; k++) begin
      check("run_state", dp_state_o, model(b, NR * k).s);
      check("run_const", dp_constant_o, exp_const(k));
      check("run_valid", out_valid_o, 1'b0);
      if (k == NS - 1) begin
        check("last_const", dp_constant_o, {6'h1A, 6'h2D, 6'h36, 6'h1B});
        start_i = 1'b0;
      end else begin
        start_i = 1'($urandom);
        state_i = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    check("b1_valid", out_valid_o, 1'b1);
    check("b1_ct", state_o, model(b, TR).s);
    tick();
    check("b1_single_pulse", out_valid_o, 1'b0);
    check("b1_idle_ready", in_ready_o, 1'b1);
    check("b1_idle_hold", state_o, model(b, TR).s);

    // Block 2: 5 cycles of back-pressure with ignored start pulses
    b = rand_blk();
    drive(b);
    start_i = 1'b1; out_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    wait_valid(NS + 5, n);
    check("b2_latency", n, NS);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", out_valid_o, 1'b1);
      check("hold_ct", state_o, model(b, TR).s);
      check("hold_ready", in_ready_o, 1'b0);
      start_i = 1'b1;
      state_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    check("hold_after", state_o, model(b, TR).s);

    // Back-to-back: accept in DONE goes straight to RUN
    b2 = rand_blk();
    drive(b2);
    start_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check("b2b_ready", in_ready_o, 1'b1);
    tick();
    start_i = 1'b0;
    check("b2b_valid_drop", out_valid_o, 1'b0);
    check("b2b_dp_state", dp_state_o, b2.s);
    check("b2b_const", dp_constant_o, 24'h3C70C1);
    wait_valid(NS + 5, n);
    check("b2b_latency", n, NS);
    check("b2b_ct", state_o, model(b2, TR).s);
    tick();
    check("b2b_done", out_valid_o, 1'b0);
    out_ready_i = 1'b0;

    // Asynchronous reset in RUN cycle 5
    b = rand_blk();
    drive(b);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_dp_state", dp_state_o, 128'd0);
    check("arst_dp_tweak", dp_tweak_o, 128'd0);
    check("arst_dp_cnt", dp_cnt_o, 128'd0);
    check("arst_state_o", state_o, 128'd0);
    check("arst_valid", out_valid_o, 1'b0);
    check("arst_const", dp_constant_o, 24'h3C70C1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    tick();
    check("arst_ready", in_ready_o, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < NS + 5; k++) begin
      seen = seen | out_valid_o;
      tick();
    end
    check("arst_no_valid", seen, 1'b0);
    out_ready_i = 1'b0;

    // Random blocks with random back-pressure
    for (int t = 0; t < 4; t++) run_txn("rand", int'($urandom_range(0, 3)));

`ifdef SKINNY_CTRL_ABORT_EN
    b = rand_blk();
    drive(b);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    check("abort_ready", in_ready_o, 1'b1);
    check("abort_dp_state", dp_state_o, 128'd0);
    check("abort_const", dp_constant_o, 24'h3C70C1);
    seen = 1'b0;
    for (int k = 0; k < NS + 5; k++) begin
      seen = seen | out_valid_o;
      tick();
    end
    check("abort_no_valid", seen, 1'b0);
    run_txn("post_abort", 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/skinny_round_ctrl.md
SKINNY_ROUND_CTRL -- requirements
Module: skinny_round_ctrl

Interface
REQ-001 Parameter numrnd, default 4: rounds computed per cycle by the attached unrolled round datapath.
REQ-002 Parameter totrnd, default 40: total rounds per block; totrnd SHALL be a multiple of numrnd.
REQ-003 clk  in  1  single clock; all flops rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start_i  in  1  request to encrypt one block; qualified by in_ready_o.
REQ-006 in_ready_o  out  1  controller can accept start_i this cycle.
REQ-007 state_i, key_i, tweak_i, cnt_i  in  128 each  plaintext, TK3, TK2, TK1 sampled on accept.
REQ-008 dp_state_o, dp_key_o, dp_tweak_o, dp_cnt_o  out  128 each  registered round inputs to the datapath.
REQ-009 dp_constant_o  out  6*numrnd  round constants; round i of the cycle at bits [6i+5:6i].
REQ-010 dp_nextstate_i, dp_nextkey_i, dp_nexttweak_i, dp_nextcnt_i  in  128 each  datapath outputs after numrnd rounds.
REQ-011 out_valid_o  out  1  ciphertext on state_o valid.
REQ-012 out_ready_i  in  1  consumer accepts ciphertext.
REQ-013 state_o  out  128  ciphertext; equals dp_state_o.

Function
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 in_ready_o = (IDLE) or (DONE and out_ready_i).
REQ-016 Accept = start_i and in_ready_o; on accept edge: state/key/tweak/cnt regs <= inputs, LFSR <= 6'h00, round counter <= 0, FSM -> RUN.
REQ-017 In RUN each edge: regs <= dp_next*_i, LFSR advances numrnd steps, round counter +1.
REQ-018 LFSR step: rc <= {rc[4:0], rc[5]^rc[4]^1'b1}; dp_constant_o round i = LFSR value after i+1 steps from register, combinational.
REQ-019 Round counter width ceil(log2(totrnd/numrnd))+1; on the update where counter = totrnd/numrnd-1, FSM -> DONE.
REQ-020 Latency: accept at edge E; out_valid_o first high in cycle after edge E+totrnd/numrnd (10 for defaults).
REQ-021 out_valid_o = (DONE); state_o held stable while out_valid_o high and out_ready_i low.
REQ-022 DONE with out_ready_i high and no accept: FSM -> IDLE; with accept same edge: FSM -> RUN directly, no idle bubble.
REQ-023 start_i in RUN, or in DONE without out_ready_i, ignored; no effect on regs.
REQ-024 In IDLE and DONE registers and LFSR hold; datapath outputs ignored.

Reset
REQ-025 rst_n low asynchronously forces FSM IDLE, all 128-bit regs 0, LFSR 0, round counter 0, out_valid_o 0; in_ready_o 1 once reset released.
REQ-026 Reset mid-RUN discards the block; no out_valid_o pulse results.

Configuration
REQ-027 Macro SKINNY_CTRL_ABORT_EN defined: adds port abort_i (in, 1); abort_i high in RUN or DONE -> IDLE at next edge, regs and LFSR cleared to 0, out_valid_o low; abort_i has priority over start_i and out_ready_i.
REQ-028 Macro undefined: no abort_i port; REQ-014..026 behaviour unchanged.

Verification
REQ-029 Reset then start_i=1 one cycle, defaults -> first RUN cycle dp_constant_o = 24'h3C70C1 (constants 01,03,07,0F); last RUN cycle constants 1B,36,2D,1A.
REQ-030 Accept at edge E with out_ready_i=1 -> out_valid_o high exactly in cycle after E+10, single cycle; state_o matches SKINNY-128-384 golden model for a fixed test vector.
REQ-031 out_ready_i=0 for 5 cycles in DONE -> out_valid_o and state_o stable 5 cycles; start_i pulses ignored.
REQ-032 DONE with out_ready_i=1 and start_i=1 same cycle -> next cycle RUN, dp_state_o = new state_i, second result after 10 further edges.
REQ-033 rst_n low at RUN cycle 5 -> all outputs 0 immediately, in_ready_o=1 after release, no out_valid_o.
REQ-034 With SKINNY_CTRL_ABORT_EN: abort_i=1 at RUN cycle 3 with start_i=1 -> IDLE next edge, no out_valid_o; subsequent start completes normally.
